// File: rtl/ahbram_arbiter.sv
// -----------------------------------------------------------------------------
// ahbram_arbiter
//
// Shares one AHB-Lite master port to the AHB-RAM slave between NUM_REQ simple
// requesters. Each requester presents a single read or write over a
// valid/ready handshake. The arbiter picks one requester round-robin, runs the
// request as one NONSEQ SINGLE transfer and returns read data and error status
// with a one-cycle response strobe. Only one transfer is outstanding at a time.
//
// Optional feature (macro AHBRAM_ARB_TIMEOUT_EN):
//   When defined, a 16-bit wait-state counter aborts a transfer that has seen
//   hready low for TIMEOUT consecutive cycles in one phase. The arbiter then
//   responds with rsp_err=1 and rsp_rdata=0. When undefined, the arbiter waits
//   for hready indefinitely.
//
// Parameters:
//   NUM_REQ  number of requester ports (2..8)
//   ADDR_W   AHB address width
//   DATA_W   AHB data width (32 or 64)
//   TIMEOUT  wait-state limit (timeout build only)
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    per-requester request pending
//   req_ready    per-requester accept strobe (one-hot or zero, combinational)
//   req_write    per-requester direction (1 = write)
//   req_addr     packed per-requester byte addresses
//   req_size     packed per-requester HSIZE encodings
//   req_wdata    packed per-requester write data
//   rsp_valid    one-cycle response strobe to the granted requester
//   rsp_rdata    read data (0 for writes and rejected requests)
//   rsp_err      error flag (slave ERROR, illegal request or timeout)
//   hsel..hwdata AHB-Lite master outputs (hburst tied to SINGLE)
//   hrdata, hready, hresp  AHB-Lite slave responses
// -----------------------------------------------------------------------------
module ahbram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*3-1:0]      req_size,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      hsel,
  output logic [ADDR_W-1:0]         haddr,
  output logic [1:0]                htrans,
  output logic                      hwrite,
  output logic [2:0]                hsize,
  output logic [2:0]                hburst,
  output logic [DATA_W-1:0]         hwdata,
  input  logic [DATA_W-1:0]         hrdata,
  input  logic                      hready,
  input  logic                      hresp
);

  localparam int IDX_W    = $clog2(NUM_REQ);
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;      // most recent grant; also the active requester
  logic [DATA_W-1:0]  wdata_q;   // write data held until the data phase

  assign hburst = 3'b000;

  // Unpack the per-requester buses so the granted fields can be indexed.
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [2:0]        size_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign size_arr[i]  = req_size[i*3 +: 3];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // Round-robin search: rotate req_valid so bit 0 is the requester after
  // 'last', take the lowest set bit, then map the offset back to an index.
  logic [NUM_REQ-1:0] rot_valid;
  logic               grant_found;
  int                 grant_off;
  int                 grant_sum;
  logic [IDX_W-1:0]   grant_idx;

  // NOTE: every variable assigned in this block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rot_valid   = NUM_REQ'({req_valid, req_valid} >> (int'(last) + 1));
    grant_found = 1'b0;
    grant_off   = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (rot_valid[off]) begin
        grant_found = 1'b1;
        grant_off   = off;
      end
    end
    grant_sum = int'(last) + 1 + grant_off;
    if (grant_sum >= NUM_REQ) grant_sum = grant_sum - NUM_REQ;
    grant_idx = IDX_W'(grant_sum);
  end

  // Legality of the candidate request: size must fit the bus and the address
  // must be naturally aligned to the transfer size.
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_size;
  logic [ADDR_W-1:0] align_mask;
  logic              illegal;

  always_comb begin
    sel_addr   = addr_arr[grant_idx];
    sel_size   = size_arr[grant_idx];
    align_mask = (ADDR_W'(1) << sel_size) - ADDR_W'(1);
    illegal    = (sel_size > 3'(MAX_SIZE)) || ((sel_addr & align_mask) != '0);
  end

  // NOTE: req_ready is combinational so the requester sees the accept in the
  // same cycle it is granted; it is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  logic tmo_hit;

`ifdef AHBRAM_ARB_TIMEOUT_EN
  // Counts consecutive hready-low cycles within one bus phase. Any state
  // change is accompanied by hready=1 or by leaving ADDR/DATA, both of which
  // clear it, so it restarts from zero on every state entry.
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || hready || (state != ADDR && state != DATA)) tmo_cnt <= '0;
    else                                                   tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = !hready && (tmo_cnt == 16'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IDX_W'(NUM_REQ - 1);
      wdata_q   <= '0;
      hsel      <= 1'b0;
      haddr     <= '0;
      htrans    <= HTRANS_IDLE;
      hwrite    <= 1'b0;
      hsize     <= 3'b000;
      hwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            last    <= grant_idx;
            wdata_q <= wdata_arr[grant_idx];
            hwrite  <= req_write[grant_idx];
            haddr   <= sel_addr;
            hsize   <= sel_size;
            if (illegal) begin
              // Rejected without touching the bus.
              state                <= RESP;
              rsp_valid[grant_idx] <= 1'b1;
              rsp_rdata            <= '0;
              rsp_err              <= 1'b1;
            end else begin
              state  <= ADDR;
              hsel   <= 1'b1;
              htrans <= HTRANS_NONSEQ;
            end
          end
        end

        ADDR: begin
          if (hready) begin
            state  <= DATA;
            hsel   <= 1'b0;
            htrans <= HTRANS_IDLE;
            hwdata <= wdata_q;
          end else if (tmo_hit) begin
            state           <= RESP;
            hsel            <= 1'b0;
            htrans          <= HTRANS_IDLE;
            rsp_valid[last] <= 1'b1;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b1;
          end
        end

        DATA: begin
          // The first cycle of a two-cycle ERROR has hready=0 and is treated
          // as an ordinary wait state; hresp is sampled with hready=1.
          if (hready) begin
            state           <= RESP;
            rsp_valid[last] <= 1'b1;
            rsp_rdata       <= hwrite ? '0 : hrdata;
            rsp_err         <= hresp;
          end else if (tmo_hit) begin
            state           <= RESP;
            rsp_valid[last] <= 1'b1;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahbram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahbram_arbiter
//
// Self-checking bench for ahbram_arbiter with NUM_REQ=2, ADDR_W=16, DATA_W=32,
// TIMEOUT=8. A behavioural AHB RAM slave with programmable address/data wait
// states and a two-cycle ERROR mode answers the bus. Expected responses are
// pushed to a scoreboard queue when a request is accepted and compared when
// rsp_valid appears, including the cycle at which it appears.
// -----------------------------------------------------------------------------
module tb_ahbram_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*3-1:0]   req_size;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              hsel;
  logic [AW-1:0]     haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DW-1:0]     hwdata;
  logic [DW-1:0]     hrdata;
  logic              hready;
  logic              hresp;

  always #5 clk = ~clk;

  ahbram_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  // ---------------------------------------------------------------- checking
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------- slave model
  logic [31:0] mem [0:255];
  int          addr_waits = 0;
  int          data_waits = 0;
  bit          err_mode   = 1'b0;
  int          a_cnt      = 0;
  int          d_cnt      = 0;
  bit          dp_active  = 1'b0;
  bit          dp_write   = 1'b0;
  logic [15:0] dp_addr    = '0;

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (hsel && htrans == 2'b10) begin
      hready = (a_cnt >= addr_waits);
    end else if (dp_active) begin
      if (err_mode) begin
        hresp  = 1'b1;
        hready = (d_cnt >= 1);
      end else begin
        hready = (d_cnt >= data_waits);
        hrdata = dp_write ? 32'h0 : mem[dp_addr[9:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      a_cnt     <= 0;
      d_cnt     <= 0;
      dp_active <= 1'b0;
    end else begin
      if (hsel && htrans == 2'b10) begin
        if (hready) begin
          a_cnt     <= 0;
          d_cnt     <= 0;
          dp_active <= 1'b1;
          dp_write  <= hwrite;
          dp_addr   <= haddr;
        end else begin
          a_cnt <= a_cnt + 1;
        end
      end else begin
        a_cnt <= 0;
      end
      if (dp_active) begin
        if (hready) begin
          dp_active <= 1'b0;
          if (dp_write && !err_mode) mem[dp_addr[9:2]] <= hwdata;
        end else begin
          d_cnt <= d_cnt + 1;
        end
      end
    end
  end

  // -------------------------------------------------------------- scoreboard
  typedef struct {
    int          idx;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  typedef struct {
    int          idx;
    bit          wr;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          aw;        // slave wait states in the address phase
    int          dw;        // slave wait states in the data phase
    bit          em;        // slave answers with a two-cycle ERROR
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;   // cycles from accept to rsp_valid
    int          exp_nseq;  // cycles with htrans=NONSEQ on the bus
  } vec_t;

  exp_t        sb[$];
  int          grant_log[$];
  exp_t        e;
  int          cyc       = 0;
  int          nseq_cnt  = 0;
  int          dp_cnt    = 0;
  logic [31:0] cur_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hsel && htrans == 2'b10) nseq_cnt++;
    if (dp_active) begin
      dp_cnt++;
      if (dp_write) check("hwdata", hwdata, cur_wdata);
    end
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", rsp_valid, '0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", rsp_valid, 64'(NR'(1) << e.idx));
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err",   rsp_err,   e.err);
        check("rsp_cycle", cyc,       e.cyc);
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, log expectations and
  // check the address phase one cycle later.
  task automatic issue(input vec_t v);
    bit   got;
    exp_t ex;
    @(posedge clk); #1;
    req_write[v.idx]             = v.wr;
    req_addr[v.idx*AW +: AW]     = v.addr;
    req_size[v.idx*3 +: 3]       = v.size;
    req_wdata[v.idx*DW +: DW]    = v.wdata;
    req_valid[v.idx]             = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      if (req_ready[v.idx]) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: requester %0d never got req_ready", v.idx);
      req_valid[v.idx] = 1'b0;
      return;
    end
    check("req_ready", req_ready, 64'(NR'(1) << v.idx));
    ex.idx   = v.idx;
    ex.rdata = v.exp_rdata;
    ex.err   = v.exp_err;
    ex.cyc   = cyc + v.exp_lat;
    sb.push_back(ex);
    grant_log.push_back(v.idx);
    if (v.wr) cur_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid[v.idx] = 1'b0;
    @(negedge clk);
    if (v.exp_nseq > 0)
      check("addr_phase", {hsel, htrans, hwrite, hsize, haddr},
            {1'b1, 2'b10, v.wr, v.size, v.addr});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses missing", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------ test
  vec_t vecs[12];
  vec_t fa[4];
  vec_t tv;
  int   exp_dp;
  bit   got;
  int   order[4];

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;

    //            idx wr  addr      size  wdata         aw dw em  exp_rdata     err lat nseq
    vecs[0]  = '{0, 1'b1, 16'h0010, 3'd2, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0,        1'b0, 3, 1};
    vecs[1]  = '{0, 1'b0, 16'h0010, 3'd2, 32'h0,        0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1};
    vecs[2]  = '{1, 1'b1, 16'h0020, 3'd2, 32'hA5A50001, 0, 3, 1'b0, 32'h0,        1'b0, 6, 1};
    vecs[3]  = '{1, 1'b0, 16'h0020, 3'd2, 32'h0,        0, 0, 1'b0, 32'hA5A50001, 1'b0, 3, 1};
    vecs[4]  = '{0, 1'b0, 16'h0013, 3'd2, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1, 1, 0};
    vecs[5]  = '{1, 1'b0, 16'h0018, 3'd3, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1, 1, 0};
    vecs[6]  = '{0, 1'b1, 16'h0030, 3'd2, 32'h12345678, 0, 0, 1'b1, 32'h0,        1'b1, 4, 1};
    vecs[7]  = '{1, 1'b0, 16'h0010, 3'd2, 32'h0,        2, 0, 1'b0, 32'hDEADBEEF, 1'b0, 5, 3};
    vecs[8]  = '{0, 1'b0, 16'h0012, 3'd1, 32'h0,        0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1};
    vecs[9]  = '{1, 1'b0, 16'h0011, 3'd1, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1, 1, 0};
    vecs[10] = '{0, 1'b0, 16'h0030, 3'd2, 32'h0,        0, 0, 1'b1, 32'h0,        1'b1, 4, 1};
    vecs[11] = '{1, 1'b0, 16'h0022, 3'd1, 32'h0,        0, 0, 1'b0, 32'hA5A50001, 1'b0, 3, 1};

    fa[0] = '{0, 1'b0, 16'h0010, 3'd2, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1};
    fa[1] = '{1, 1'b0, 16'h0020, 3'd2, 32'h0, 0, 0, 1'b0, 32'hA5A50001, 1'b0, 3, 1};
    fa[2] = '{0, 1'b0, 16'h0012, 3'd1, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1};
    fa[3] = '{1, 1'b0, 16'h0022, 3'd1, 32'h0, 0, 0, 1'b0, 32'hA5A50001, 1'b0, 3, 1};

    // Reset values, with both requesters asserting during reset.
    repeat (3) @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    check("reset_req_ready", req_ready, '0);
    check("reset_htrans",    htrans,    2'b00);
    check("reset_hsel",      hsel,      1'b0);
    check("reset_haddr",     haddr,     '0);
    check("reset_hwrite",    hwrite,    1'b0);
    check("reset_hsize",     hsize,     3'b000);
    check("reset_hwdata",    hwdata,    '0);
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_rsp_rdata", rsp_rdata, '0);
    check("reset_rsp_err",   rsp_err,   1'b0);
    check("hburst",          hburst,    3'b000);
    req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven single transactions.
    for (int k = 0; k < 12; k++) begin
      addr_waits = vecs[k].aw;
      data_waits = vecs[k].dw;
      err_mode   = vecs[k].em;
      nseq_cnt   = 0;
      dp_cnt     = 0;
      issue(vecs[k]);
      drain();
      exp_dp = (vecs[k].exp_nseq == 0) ? 0 : (vecs[k].em ? 2 : vecs[k].dw + 1);
      check($sformatf("nseq_cycles[%0d]", k), nseq_cnt, vecs[k].exp_nseq);
      check($sformatf("data_cycles[%0d]", k), dp_cnt,   exp_dp);
    end

    // Reset in the middle of a data phase: no response, bus idle next cycle.
    addr_waits = 0;
    data_waits = 6;
    err_mode   = 1'b0;
    @(posedge clk); #1;
    req_write[1]       = 1'b0;
    req_addr[AW +: AW] = 16'h0020;
    req_size[3 +: 3]   = 3'd2;
    req_valid[1]       = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1'b1;
    end
    check("midop_accept", got, 1'b1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk);
      if (dp_active) got = 1'b1;
    end
    check("midop_data_phase", got, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midop_htrans",    htrans,    2'b00);
    check("midop_hsel",      hsel,      1'b0);
    check("midop_rsp_valid", rsp_valid, '0);
    @(negedge clk);
    check("midop_rsp_valid2", rsp_valid, '0);
    data_waits = 0;
    @(posedge clk); #1 rst = 1'b0;

    // Fairness after a fresh reset: both requesters contend for 4 grants.
    grant_log.delete();
    fork
      begin issue(fa[0]); issue(fa[2]); end
      begin issue(fa[1]); issue(fa[3]); end
    join
    drain();
    order = '{0, 1, 0, 1};
    check("fair_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check($sformatf("fair_grant[%0d]", k), grant_log[k], order[k]);

`ifdef AHBRAM_ARB_TIMEOUT_EN
    // Slave stalls the address phase past TIMEOUT=8.
    addr_waits = 20;
    nseq_cnt   = 0;
    tv = '{0, 1'b0, 16'h0010, 3'd2, 32'h0, 20, 0, 1'b0, 32'h0, 1'b1, 9, 8};
    issue(tv);
    drain();
    check("timeout_nseq_cycles", nseq_cnt, 8);
    check("timeout_htrans",      htrans,   2'b00);
    addr_waits = 0;
    tv = '{1, 1'b0, 16'h0010, 3'd2, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1};
    issue(tv);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
